// File: rtl/fft_stream_pkg.sv
// Shared types and widths for the FFT sample streaming path.
// Holds the reader state encoding and default sample/level widths.
package fft_stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fft_state_e;

    localparam int FFT_SAMPLE_W = 16;
    localparam int FFT_LEVEL_W  = 14;
    localparam int SKID_DEPTH   = 3;

    function automatic int fft_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fft_axis_skid3.sv
// Three-entry register FIFO with a registered head; absorbs the sample FIFO
// read latency so the stream keeps one beat per clock under back-pressure.
module fft_axis_skid3
    import fft_stream_pkg::*;
#(
    parameter int WIDTH = FFT_SAMPLE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem_reg  [SKID_DEPTH];
    logic [WIDTH-1:0] mem_next [SKID_DEPTH];
    logic [1:0]       occ_reg;
    logic [1:0]       occ_next;
    logic [1:0]       wr_slot;
    logic             rd_ok;
    logic             wr_ok;

    assign rd_ok   = rd_en && (occ_reg != 2'd0);
    assign wr_ok   = wr_en && ((occ_reg != 2'd3) || rd_ok);
    // Entries shift toward the head on a read, so a simultaneous write lands one slot lower.
    assign wr_slot = rd_ok ? (occ_reg - 2'd1) : occ_reg;

    generate
        for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] shift_in;
            if (gi < SKID_DEPTH - 1) begin : g_shift
                assign shift_in = mem_reg[gi+1];
            end else begin : g_last
                assign shift_in = mem_reg[gi];
            end
            assign mem_next[gi] = (wr_ok && (wr_slot == 2'(gi))) ? wr_data :
                                  rd_ok                           ? shift_in :
                                                                    mem_reg[gi];
        end
    endgenerate

    assign occ_next = occ_reg + {1'b0, wr_ok} - {1'b0, rd_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg <= 2'd0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            occ_reg <= occ_next;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_reg[i] <= mem_next[i];
            end
        end
    end

    assign rd_data = mem_reg[0];
    assign occ     = occ_reg;

endmodule

// File: rtl/fft_fifo_axis_reader.sv
// Drains fixed-length frames from the FFT sample FIFO onto an AXI-Stream
// master; a frame starts only once the FIFO already holds all of it.
module fft_fifo_axis_reader
    import fft_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = FFT_SAMPLE_W,
    parameter int LEVEL_WIDTH = FFT_LEVEL_W,
    parameter int FRAME_LEN   = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0]  fifo_rd_water_level,
    output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int CMP_W = fft_max(LEVEL_WIDTH, CNT_W) + 1;

    fft_state_e       state_reg;
    fft_state_e       state_next;
    logic [CNT_W-1:0] issued_reg;
    logic [CNT_W-1:0] accepted_reg;
    logic             inflight_reg;
    logic             frame_done_reg;

    logic [CMP_W-1:0] level_ext;
    logic             frame_ready;
    logic             launch;
    logic             frame_end;
    logic             beat;
    logic [1:0]       occ;
    logic [2:0]       pending;
    logic [DATA_WIDTH-1:0] head_data;

    assign level_ext   = CMP_W'(fifo_rd_water_level);
    assign frame_ready = level_ext >= CMP_W'(FRAME_LEN);
    assign beat        = m_axis_tvalid && m_axis_tready;
    assign pending     = {1'b0, occ} + {2'b00, inflight_reg};

    // Read enable depends only on registered state and the empty flag, never on tready.
    assign fifo_rd_en = (state_reg == STREAM) &&
                        (issued_reg < CNT_W'(FRAME_LEN)) &&
                        !fifo_rd_empty &&
                        (pending < 3'd3);

    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        frame_end  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && frame_ready) begin
                    state_next = STREAM;
                    launch     = 1'b1;
                end
            end
            STREAM: begin
                if (beat && m_axis_tlast) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_reg     <= '0;
            accepted_reg   <= '0;
            inflight_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            if (launch) begin
                issued_reg   <= '0;
                accepted_reg <= '0;
            end else begin
                if (fifo_rd_en) begin
                    issued_reg <= issued_reg + CNT_W'(1);
                end
                if (beat) begin
                    accepted_reg <= accepted_reg + CNT_W'(1);
                end
            end
            inflight_reg   <= fifo_rd_en;
            frame_done_reg <= frame_end;
        end
    end

    // FIFO data is valid one cycle after the read, i.e. while inflight is set.
    fft_axis_skid3 #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (inflight_reg),
        .wr_data (fifo_rd_data),
        .rd_en   (beat),
        .rd_data (head_data),
        .occ     (occ)
    );

    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tdata  = {{DATA_WIDTH{1'b0}}, head_data};
    assign m_axis_tlast  = m_axis_tvalid && (accepted_reg == CNT_W'(FRAME_LEN - 1));
    assign busy          = (state_reg != IDLE);
    assign frame_done    = frame_done_reg;

endmodule
